// File: rtl/player_stats_bank.sv
// Per-player BCD score and lives bank with bonus-life awards, a lives ceiling
// and game-over freezing; the renderer reads one player through a combinational port.
module player_stats_bank #(
    parameter int NUM_PLAYERS  = 2,
    parameter int PW           = 1,
    parameter int SCORE_DIGITS = 4,
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 9,
    parameter int BONUS_DIGIT  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_game,
    input  logic [PW-1:0]             player,
    input  logic                      incscore,
    input  logic [3:0]                add_pts,
    input  logic                      declives,
    input  logic [PW-1:0]             rd_player,
    output logic [4*SCORE_DIGITS-1:0] rd_score,
    output logic [3:0]                rd_lives,
    output logic                      rd_game_over,
    output logic                      bonus_pulse
);
    localparam int SW = 4 * SCORE_DIGITS;

    logic [SW-1:0] score_q [NUM_PLAYERS];
    logic [SW-1:0] score_d [NUM_PLAYERS];
    logic [3:0]    lives_q [NUM_PLAYERS];
    logic [3:0]    lives_d [NUM_PLAYERS];
    logic          bonus_pulse_q, bonus_pulse_d;

    logic          tgt_valid;
    logic [SW-1:0] old_score, sum_raw, new_score;
    logic [3:0]    old_lives, new_lives, carry;
    logic [4:0]    acc;
    logic          inc_active, dec_active, bonus;

    always_comb begin
        tgt_valid = (int'(player) < NUM_PLAYERS);
        old_score = '0;
        old_lives = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (tgt_valid && player == PW'(i)) begin
                old_score = score_q[i];
                old_lives = lives_q[i];
            end
        end
    end

    // Ripple BCD add; the first carry-in is the clamped point value itself.
    always_comb begin
        carry   = (add_pts > 4'd9) ? 4'd9 : add_pts;
        sum_raw = '0;
        acc     = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            acc = {1'b0, old_score[4*d +: 4]} + {1'b0, carry};
            if (acc > 5'd9) begin
                sum_raw[4*d +: 4] = 4'(acc - 5'd10);
                carry             = 4'd1;
            end else begin
                sum_raw[4*d +: 4] = acc[3:0];
                carry             = 4'd0;
            end
        end
        new_score = (carry != 4'd0) ? {SCORE_DIGITS{4'h9}} : sum_raw;
    end

    always_comb begin
        inc_active = incscore && tgt_valid && (old_lives != 4'd0);
        dec_active = declives && tgt_valid;
        // Any change in the upper digit group means the score crossed a bonus boundary.
        bonus      = inc_active && (BONUS_DIGIT != 0) &&
                     (new_score[SW-1:4*BONUS_DIGIT] != old_score[SW-1:4*BONUS_DIGIT]);
        new_lives  = old_lives;
        if (bonus && !dec_active) begin
            new_lives = (old_lives >= 4'(MAX_LIVES)) ? 4'(MAX_LIVES) : old_lives + 4'd1;
        end else if (!bonus && dec_active && old_lives != 4'd0) begin
            new_lives = old_lives - 4'd1;
        end
    end

    always_comb begin
        score_d       = score_q;
        lives_d       = lives_q;
        bonus_pulse_d = 1'b0;
        if (new_game) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_d[i] = '0;
                lives_d[i] = 4'(START_LIVES);
            end
        end else begin
            bonus_pulse_d = bonus;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (tgt_valid && player == PW'(i)) begin
                    if (inc_active) score_d[i] = new_score;
                    lives_d[i] = new_lives;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= '0;
                lives_q[i] <= 4'(START_LIVES);
            end
            bonus_pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= score_d[i];
                lives_q[i] <= lives_d[i];
            end
            bonus_pulse_q <= bonus_pulse_d;
        end
    end

    always_comb begin
        rd_score     = '0;
        rd_lives     = '0;
        rd_game_over = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (rd_player == PW'(i)) begin
                rd_score     = score_q[i];
                rd_lives     = lives_q[i];
                rd_game_over = (lives_q[i] == 4'd0);
            end
        end
    end

    assign bonus_pulse = bonus_pulse_q;

endmodule

// File: tb/tb_player_stats_bank.sv
// Bench for player_stats_bank: directed scenarios plus random strobes, compared
// against an integer-valued score/lives model.
module tb_player_stats_bank;
    localparam int NP = 2;
    localparam int PWB = 2;
    localparam int SD = 4;
    localparam int MAXS = 9999;
    localparam int BSTEP = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          new_game = 1'b0;
    logic [PWB-1:0] player = '0;
    logic          incscore = 1'b0;
    logic [3:0]    add_pts = '0;
    logic          declives = 1'b0;
    logic [PWB-1:0] rd_player = '0;
    logic [4*SD-1:0] rd_score;
    logic [3:0]    rd_lives;
    logic          rd_game_over;
    logic          bonus_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int m_score [NP];
    int m_lives [NP];
    bit m_bonus;

    player_stats_bank #(.NUM_PLAYERS(NP), .PW(PWB), .SCORE_DIGITS(SD), .START_LIVES(3),
                        .MAX_LIVES(9), .BONUS_DIGIT(3)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .player(player),
        .incscore(incscore), .add_pts(add_pts), .declives(declives),
        .rd_player(rd_player), .rd_score(rd_score), .rd_lives(rd_lives),
        .rd_game_over(rd_game_over), .bonus_pulse(bonus_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [4*SD-1:0] to_bcd(int v);
        logic [4*SD-1:0] r = '0;
        for (int d = 0; d < SD; d++) r[4*d +: 4] = 4'((v / (10 ** d)) % 10);
        return r;
    endfunction

    function automatic logic [4*SD-1:0] exp_score(int i);
        return (i < NP) ? to_bcd(m_score[i]) : '0;
    endfunction

    function automatic logic [3:0] exp_lives(int i);
        return (i < NP) ? 4'(m_lives[i]) : 4'd0;
    endfunction

    function automatic logic exp_go(int i);
        return (i < NP) && (m_lives[i] == 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NP; i++) begin
            m_score[i] = 0;
            m_lives[i] = 3;
        end
        m_bonus = 0;
    endtask

    // One clock of stimulus; the model applies the game rules to whole numbers.
    task automatic drive(int p, bit inc, int pts, bit dec, bit ng);
        int ns;
        player = PWB'(p); incscore = inc; add_pts = 4'(pts); declives = dec; new_game = ng;
        if (ng) begin
            model_clear();
        end else begin
            m_bonus = 0;
            if (p < NP) begin
                if (inc && m_lives[p] > 0) begin
                    ns = m_score[p] + ((pts > 9) ? 9 : pts);
                    if (ns > MAXS) ns = MAXS;
                    m_bonus = (ns / BSTEP) != (m_score[p] / BSTEP);
                    m_score[p] = ns;
                end
                if (m_bonus && !dec) m_lives[p] = (m_lives[p] >= 9) ? 9 : m_lives[p] + 1;
                else if (!m_bonus && dec && m_lives[p] > 0) m_lives[p] = m_lives[p] - 1;
            end
        end
        @(posedge clk);
        #1;
        incscore = 0; declives = 0; new_game = 0;
        $display("txn p=%0d inc=%0b pts=%0d dec=%0b ng=%0b -> bonus=%0b", p, inc, pts, dec, ng, m_bonus);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rd_player = PWB'(i); #1;
            n_cmp++;
            if (rd_score !== exp_score(i) || rd_lives !== exp_lives(i) || rd_game_over !== exp_go(i)) begin
                n_err++;
                $display("FAIL reset_rd p%0d: got %h/%0d/%b want %h/%0d/%b", i, rd_score, rd_lives,
                         rd_game_over, exp_score(i), exp_lives(i), exp_go(i));
            end
        end
        n_cmp++;
        if (bonus_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_bonus: got %b want 0", bonus_pulse);
        end
    endtask

    task automatic test_carry_bonus();
        for (int k = 0; k < 110; k++) drive(0, 1, 9, 0, 0);
        drive(0, 1, 5, 0, 0);
        rd_player = 0; #1;
        n_cmp++;
        if (rd_score !== 16'h0995) begin
            n_err++;
            $display("FAIL carry_pre: got %h want 0995", rd_score);
        end
        drive(0, 1, 7, 0, 0);
        rd_player = 0; #1;
        n_cmp++;
        if (rd_score !== 16'h1002 || rd_lives !== 4'd4 || bonus_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL carry_bonus: got %h/%0d/%b want 1002/4/1", rd_score, rd_lives, bonus_pulse);
        end
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (bonus_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL bonus_width: got %b want 0", bonus_pulse);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 1111; k++) begin
            drive(1, 1, (k == 1110) ? 8 : 9, 0, 0);
            n_cmp++;
            if (bonus_pulse !== m_bonus) begin
                n_err++;
                $display("FAIL climb_bonus step %0d: got %b want %b", k, bonus_pulse, m_bonus);
            end
        end
        rd_player = 1; #1;
        n_cmp++;
        if (rd_score !== 16'h9998 || rd_lives !== 4'd9) begin
            n_err++;
            $display("FAIL sat_pre: got %h/%0d want 9998/9", rd_score, rd_lives);
        end
        drive(1, 1, 5, 0, 0);
        drive(1, 1, 9, 0, 0);
        n_cmp++;
        if (rd_score !== 16'h9999 || bonus_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL sat_hold: got %h/%b want 9999/0", rd_score, bonus_pulse);
        end
    endtask

    task automatic test_game_over();
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 1, 0);
        rd_player = 0; #1;
        n_cmp++;
        if (rd_lives !== 4'd0 || rd_game_over !== 1'b1) begin
            n_err++;
            $display("FAIL game_over: got %0d/%b want 0/1", rd_lives, rd_game_over);
        end
        drive(0, 1, 5, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            rd_player = PWB'(i); #1;
            n_cmp++;
            if (rd_score !== exp_score(i) || rd_lives !== exp_lives(i) || rd_game_over !== exp_go(i)) begin
                n_err++;
                $display("FAIL frozen_rd p%0d: got %h/%0d/%b want %h/%0d/%b", i, rd_score, rd_lives,
                         rd_game_over, exp_score(i), exp_lives(i), exp_go(i));
            end
        end
    endtask

    task automatic test_bonus_dec();
        drive(0, 1, 9, 1, 1);
        for (int i = 0; i < 4; i++) begin
            rd_player = PWB'(i); #1;
            n_cmp++;
            if (rd_score !== exp_score(i) || rd_lives !== exp_lives(i)) begin
                n_err++;
                $display("FAIL newgame_rd p%0d: got %h/%0d want %h/%0d", i, rd_score, rd_lives,
                         exp_score(i), exp_lives(i));
            end
        end
        for (int k = 0; k < 110; k++) drive(0, 1, 9, 0, 0);
        drive(0, 1, 5, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 7, 1, 0);
        rd_player = 0; #1;
        n_cmp++;
        if (rd_score !== 16'h1002 || rd_lives !== 4'd1 || rd_game_over !== 1'b0 || bonus_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL bonus_dec: got %h/%0d/%b/%b want 1002/1/0/1", rd_score, rd_lives,
                     rd_game_over, bonus_pulse);
        end
        drive(0, 0, 0, 1, 0);
        n_cmp++;
        if (rd_lives !== 4'd0 || rd_game_over !== 1'b1) begin
            n_err++;
            $display("FAIL last_life: got %0d/%b want 0/1", rd_lives, rd_game_over);
        end
    endtask

    task automatic test_invalid_reset();
        drive(1, 1, 9, 0, 0);
        drive(2, 1, 9, 1, 0);
        drive(3, 1, 5, 1, 0);
        for (int i = 0; i < 4; i++) begin
            rd_player = PWB'(i); #1;
            n_cmp++;
            if (rd_score !== exp_score(i) || rd_lives !== exp_lives(i) || bonus_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL invalid_rd p%0d: got %h/%0d/%b want %h/%0d/0", i, rd_score, rd_lives,
                         bonus_pulse, exp_score(i), exp_lives(i));
            end
        end
        player = 1; incscore = 1; add_pts = 4'd9;
        #2 reset = 1;
        #1;
        model_clear();
        rd_player = 1; #1;
        n_cmp++;
        if (rd_score !== 16'h0000 || rd_lives !== 4'd3) begin
            n_err++;
            $display("FAIL async_reset: got %h/%0d want 0000/3", rd_score, rd_lives);
        end
        @(posedge clk); #1;
        reset = 0; incscore = 0;
        drive(0, 1, 8, 0, 0);
        drive(1, 1, 6, 0, 0);
        drive(1, 1, 9, 0, 1);
        for (int i = 0; i < 2; i++) begin
            rd_player = PWB'(i); #1;
            n_cmp++;
            if (rd_score !== 16'h0000 || rd_lives !== 4'd3 || bonus_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL clear_rd p%0d: got %h/%0d/%b want 0000/3/0", i, rd_score, rd_lives, bonus_pulse);
            end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 100; k++) drive(p, 1, 9, 0, 0);
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
            n_cmp++;
            if (bonus_pulse !== m_bonus) begin
                n_err++;
                $display("FAIL rand_bonus step %0d: got %b want %b", k, bonus_pulse, m_bonus);
            end
            for (int i = 0; i < 4; i++) begin
                rd_player = PWB'(i); #1;
                n_cmp++;
                if (rd_score !== exp_score(i) || rd_lives !== exp_lives(i) || rd_game_over !== exp_go(i)) begin
                    n_err++;
                    $display("FAIL rand_rd step %0d p%0d: got %h/%0d/%b want %h/%0d/%b", k, i, rd_score,
                             rd_lives, rd_game_over, exp_score(i), exp_lives(i), exp_go(i));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        test_reset();
        test_carry_bonus();
        test_saturation();
        test_game_over();
        test_bonus_dec();
        test_invalid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
